pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It collects stall sources and drives the shared `stall` bus (`StallBus`=6) consumed by PC, IF, ID, EX, MEM and WB:
- ID load-use request.
- EX multi-cycle divider.
- MEM data-SRAM wait.

It holds an FSM so that multi-cycle waits are sequenced without the requesters re-asserting every cycle.

Parameters:
- DIV_TIMEOUT, 40, maximum cycles spent in DIV before forced release.
- CNT_W, 6, width of the divider wait counter; must satisfy 2^CNT_W > DIV_TIMEOUT.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- stallreq_from_id  in  1  load-use hazard detected in ID this cycle.
- div_start  in  1  div/divu issuing in EX this cycle.
- div_ready  in  1  divider result valid.
- mem_req  in  1  MEM stage has an outstanding data-SRAM access.
- mem_ack  in  1  data-SRAM access completes this cycle.
- stall  out  6  stall[0]=PC … stall[5]=WB; 1=`Stop`.
- div_busy  out  1  FSM in DIV.
- div_err  out  1  sticky divider-timeout flag.
- perf_stall_cnt  out  32  cycles with stall!=0 (optional feature).
- perf_div_cnt  out  32  cycles spent in DIV (optional feature).

Behaviour:
- Stall patterns:
  - NONE = 000000
  - LU = 000111 (PC/IF/ID hold; EX gets bubble)
  - EXS = 001111
  - MEMS = 011111
- `stall` is combinational from registered state plus current inputs, so a request stalls in the same cycle.
- Registered state: `state` (RUN, DIV, MEM), `div_cnt`, `div_err`, perf counters.
- While rst=1: stall=NONE, state=RUN, div_cnt=0, div_err=0, perf counters=0. Reset mid-wait abandons the wait immediately.
- RUN, evaluated in priority order:
  - mem_req & ~mem_ack: stall=MEMS, next MEM.
  - else div_start: stall=EXS, next DIV, div_cnt<=1.
  - else stallreq_from_id: stall=LU, stay RUN. The bubble lasts as long as the request is held; ID drops it once the load leaves EX.
  - else stall=NONE.
  - mem_req & mem_ack in the same cycle counts as no MEM stall.
- DIV:
  - div_ready: stall follows the RUN rules with the div_start term ignored; next RUN; div_cnt<=0.
  - Timeout (~div_ready & div_cnt==DIV_TIMEOUT): treated exactly as div_ready, and div_err<=1.
  - Otherwise: stall=MEMS if mem_req & ~mem_ack, else EXS; stay DIV; div_cnt<=div_cnt+1. The MEM wait has priority but the divider keeps counting.
  - div_start is ignored while in DIV.
- MEM:
  - ~mem_ack: stall=MEMS, stay MEM.
  - mem_ack: stall follows the RUN rules with the mem term ignored, so DIV entry is allowed that cycle; next RUN or DIV accordingly.
- div_busy = (state==DIV).
- div_err is cleared only by rst.
- div_start & div_ready in the same RUN cycle: div_ready is ignored and DIV is entered.
- No state ever stalls WB (stall[5] is constant 0).

Optional Feature:
- Macro: PIPE_STALL_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle stall!=NONE.
  - perf_div_cnt increments each cycle state==DIV.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: both ports are tied to 32'b0 and no counter flops are generated.

Decomposition:
- Shared header lib/defines.vh gains:
  - STALL_NONE, STALL_LU, STALL_EXS, STALL_MEMS pattern constants.
  - State encodings PSC_RUN=2'd0, PSC_DIV=2'd1, PSC_MEM=2'd2.
  - The existing StallBus, Stop, NoStop are reused.
- One sub-module, pipe_stall_ctrl_sat_cnt: a 32-bit saturating counter with inc/clear, instantiated twice under the macro.

Test Plan:
- stallreq_from_id=1 for 2 cycles, nothing else → stall=000111 both cycles, then 000000; state stays RUN.
- div_start pulse, div_ready 8 cycles later → stall=001111 for 8 cycles and div_busy=1; on the ready cycle stall=000000; div_err=0.
- div_start, div_ready never asserted, DIV_TIMEOUT=40 → release after 40 DIV cycles; div_err=1 and held until rst.
- In DIV, mem_req=1 with mem_ack low for 3 cycles → stall=011111 for those cycles, div_cnt still advances, then back to 001111.
- mem_req=1 and ack after 4 cycles, with div_start asserted on the ack cycle → 4 cycles of 011111, then 001111 and state=DIV.
- rst asserted asynchronously mid-DIV → stall=000000 and state=RUN within the same cycle; with PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall sequencer: stall bus width,
// per-stage stop encodings, the stall patterns and the FSM state codes.
package pipe_stall_ctrl_pkg;

    localparam int   StallBus = 6;
    localparam logic Stop     = 1'b1;
    localparam logic NoStop   = 1'b0;

    // Bit 0 is PC, bit 5 is WB; WB is never held.
    localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
    localparam logic [StallBus-1:0] STALL_LU   = 6'b000111;
    localparam logic [StallBus-1:0] STALL_EXS  = 6'b001111;
    localparam logic [StallBus-1:0] STALL_MEMS = 6'b011111;

    localparam logic [1:0] PSC_RUN = 2'd0;
    localparam logic [1:0] PSC_DIV = 2'd1;
    localparam logic [1:0] PSC_MEM = 2'd2;

    // Stall pattern for the free-running cases once any divider term is resolved.
    function automatic logic [StallBus-1:0] base_stall(input logic mem_wait, input logic lu);
        if (mem_wait)
            return STALL_MEMS;
        else if (lu)
            return STALL_LU;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module pipe_stall_ctrl_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != 32'hFFFF_FFFF))
            cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer for the 5-stage core: merges load-use, divider and
// data-SRAM waits onto the stall bus. Perf counters enabled by PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                div_start,
    input  logic                div_ready,
    input  logic                mem_req,
    input  logic                mem_ack,
    output logic [StallBus-1:0] stall,
    output logic                div_busy,
    output logic                div_err,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_div_cnt
);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
    logic             mem_wait;
    logic             div_tmo;
    logic             div_done;

    assign mem_wait = mem_req & ~mem_ack;
    assign div_tmo  = ~div_ready & (div_cnt == CNT_W'(DIV_TIMEOUT));
    assign div_done = div_ready | div_tmo;

    always_comb begin
        stall       = STALL_NONE;
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        case (state)
            PSC_RUN: begin
                if (mem_wait) begin
                    stall     = STALL_MEMS;
                    state_nxt = PSC_MEM;
                end else if (div_start) begin
                    stall       = STALL_EXS;
                    state_nxt   = PSC_DIV;
                    div_cnt_nxt = CNT_W'(1);
                end else begin
                    stall = base_stall(1'b0, stallreq_from_id);
                end
            end
            PSC_DIV: begin
                if (div_done) begin
                    stall       = base_stall(mem_wait, stallreq_from_id);
                    state_nxt   = PSC_RUN;
                    div_cnt_nxt = '0;
                end else begin
                    // A pending SRAM access widens the stall but the divider keeps timing.
                    stall       = mem_wait ? STALL_MEMS : STALL_EXS;
                    div_cnt_nxt = div_cnt + CNT_W'(1);
                end
            end
            PSC_MEM: begin
                if (!mem_ack) begin
                    stall = STALL_MEMS;
                end else if (div_start) begin
                    stall       = STALL_EXS;
                    state_nxt   = PSC_DIV;
                    div_cnt_nxt = CNT_W'(1);
                end else begin
                    stall     = base_stall(1'b0, stallreq_from_id);
                    state_nxt = PSC_RUN;
                end
            end
            default: begin
                state_nxt   = PSC_RUN;
                div_cnt_nxt = '0;
            end
        endcase
        // Reset abandons any wait immediately, independent of the clock.
        if (rst)
            stall = STALL_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PSC_RUN;
            div_cnt <= '0;
            div_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            if ((state == PSC_DIV) && div_tmo)
                div_err <= 1'b1;
        end
    end

    assign div_busy = (state == PSC_DIV);

`ifdef PIPE_STALL_CTRL_PERF_EN
    pipe_stall_ctrl_sat_cnt u_perf_stall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall != STALL_NONE),
        .cnt (perf_stall_cnt)
    );

    pipe_stall_ctrl_sat_cnt u_perf_div (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (state == PSC_DIV),
        .cnt (perf_div_cnt)
    );
`else
    assign perf_stall_cnt = 32'b0;
    assign perf_div_cnt   = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: per-cycle vector table plus hand-built
// sequences for divider timeout and asynchronous reset mid-wait.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LU   = 6'b000111;
    localparam logic [5:0] S_EXS  = 6'b001111;
    localparam logic [5:0] S_MEMS = 6'b011111;

    typedef struct packed {
        logic       lu;
        logic       ds;
        logic       dr;
        logic       mr;
        logic       ma;
        logic [5:0] stall;
        logic       busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id, div_start, div_ready, mem_req, mem_ack;
    logic [5:0]  stall;
    logic        div_busy, div_err;
    logic [31:0] perf_stall_cnt, perf_div_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned tally_stall = 0;
    int unsigned tally_div   = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_TIMEOUT(40), .CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .div_start        (div_start),
        .div_ready        (div_ready),
        .mem_req          (mem_req),
        .mem_ack          (mem_ack),
        .stall            (stall),
        .div_busy         (div_busy),
        .div_err          (div_err),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_div_cnt     (perf_div_cnt)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compares all outputs against the expected values for the current cycle.
    task automatic check(input string name, input logic [5:0] es, input logic eb, input logic ee);
        logic [31:0] exp_ps, exp_pd;
`ifdef PIPE_STALL_CTRL_PERF_EN
        exp_ps = tally_stall;
        exp_pd = tally_div;
`else
        exp_ps = 32'd0;
        exp_pd = 32'd0;
`endif
        cmp({name, ".stall"}, {26'd0, stall}, {26'd0, es});
        cmp({name, ".div_busy"}, {31'd0, div_busy}, {31'd0, eb});
        cmp({name, ".div_err"}, {31'd0, div_err}, {31'd0, ee});
        cmp({name, ".perf_stall"}, perf_stall_cnt, exp_ps);
        cmp({name, ".perf_div"}, perf_div_cnt, exp_pd);
        if (es != S_NONE) tally_stall++;
        if (eb) tally_div++;
    endtask

    // One clock cycle: entered at posedge+1, inputs applied, outputs checked on negedge.
    task automatic step(input string name, input logic lu, input logic ds, input logic dr,
                        input logic mr, input logic ma,
                        input logic [5:0] es, input logic eb, input logic ee);
        stallreq_from_id = lu;
        div_start        = ds;
        div_ready        = dr;
        mem_req          = mr;
        mem_ack          = ma;
        @(negedge clk);
        check(name, es, eb, ee);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic lu, input logic ds, input logic dr, input logic mr,
                       input logic ma, input logic [5:0] es, input logic eb);
        vec_t v;
        v = '{lu: lu, ds: ds, dr: dr, mr: mr, ma: ma, stall: es, busy: eb};
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // load-use bubble for two cycles
        add(0,0,0,0,0, S_NONE,0);
        add(1,0,0,0,0, S_LU,  0);
        add(1,0,0,0,0, S_LU,  0);
        add(0,0,0,0,0, S_NONE,0);
        // divide, ready 8 cycles after start
        add(0,1,0,0,0, S_EXS, 0);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0, S_EXS, 1);
        add(0,0,1,0,0, S_NONE,1);
        add(0,0,0,0,0, S_NONE,0);
        // SRAM wait while dividing
        add(0,1,0,0,0, S_EXS, 0);
        add(0,1,0,0,0, S_EXS, 1);
        for (int i = 0; i < 3; i++) add(0,0,0,1,0, S_MEMS, 1);
        add(0,0,0,0,0, S_EXS, 1);
        add(0,0,1,0,0, S_NONE,1);
        add(0,0,0,0,0, S_NONE,0);
        // SRAM wait with divide issued on the ack cycle
        for (int i = 0; i < 4; i++) add(0,0,0,1,0, S_MEMS, 0);
        add(0,1,0,1,1, S_EXS, 0);
        add(0,0,0,0,0, S_EXS, 1);
        add(0,0,1,0,0, S_NONE,1);
        add(0,0,0,0,0, S_NONE,0);
        // priority corners
        add(0,0,0,1,1, S_NONE,0);
        add(0,1,1,0,0, S_EXS, 0);
        add(1,0,1,0,0, S_LU,  1);
        add(0,0,0,0,0, S_NONE,0);
        add(0,1,0,1,0, S_MEMS,0);
        add(1,0,0,1,1, S_LU,  0);
        add(0,0,0,0,0, S_NONE,0);

        // requests during reset must not stall
        rst = 1'b1;
        stallreq_from_id = 1'b1; div_start = 1'b1; div_ready = 1'b0;
        mem_req = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        check("in_reset", S_NONE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stallreq_from_id = 1'b0; div_start = 1'b0; mem_req = 1'b0;

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].lu, vecs[i].ds, vecs[i].dr,
                 vecs[i].mr, vecs[i].ma, vecs[i].stall, vecs[i].busy, 1'b0);

        // timeout with an SRAM wait in the middle; counter keeps running
        step("tmo_start", 0,1,0,0,0, S_EXS, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            logic mr;
            logic [5:0] es;
            mr = (i >= 5) && (i <= 7);
            es = (i == 40) ? S_NONE : (mr ? S_MEMS : S_EXS);
            step($sformatf("tmo%0d", i), 0,0,0,mr,0, es, 1, 0);
        end
        step("tmo_after0", 0,0,0,0,0, S_NONE, 0, 1);
        step("tmo_after1", 0,0,0,0,0, S_NONE, 0, 1);
        step("err_hold0",  0,1,0,0,0, S_EXS,  0, 1);
        step("err_hold1",  0,0,1,0,0, S_NONE, 1, 1);
        step("err_hold2",  0,0,0,0,0, S_NONE, 0, 1);

        // asynchronous reset in the middle of a divide
        step("rst_div0", 0,1,0,0,0, S_EXS, 0, 1);
        step("rst_div1", 0,0,0,0,0, S_EXS, 1, 1);
        #2;
        rst = 1'b1;
        tally_stall = 0;
        tally_div   = 0;
        #1;
        check("async_rst", S_NONE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst0", 0,0,0,0,0, S_NONE, 0, 0);
        step("post_rst1", 0,1,0,0,0, S_EXS,  0, 0);
        step("post_rst2", 0,0,1,0,0, S_NONE, 1, 0);
        step("post_rst3", 0,0,0,0,0, S_NONE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
